// File: rtl/sd_response_receiver_pkg.sv
// Shared SD SPI definitions: response-type encodings, frame lengths and
// default timeout limits used by the command sender and response receiver.
package sd_response_receiver_pkg;

  typedef enum logic [1:0] {
    RESP_R1   = 2'd0,
    RESP_R1B  = 2'd1,
    RESP_R3R7 = 2'd2,
    RESP_RSVD = 2'd3
  } resp_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECEIVE,
    S_BUSY
  } rx_state_t;

  localparam int unsigned RESP_W           = 40;
  localparam int unsigned LEN_R1           = 8;
  localparam int unsigned LEN_R3R7         = 40;
  localparam int unsigned BIT_CNT_W        = 6;
  localparam int unsigned NCR_MAX_DEFAULT  = 80;
  localparam int unsigned BUSY_MAX_DEFAULT = 65535;

  function automatic int unsigned wait_cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sd_response_receiver_if.sv
// Handshake and data bundle between the SD controller and the response receiver.
interface sd_response_receiver_if;
  import sd_response_receiver_pkg::*;

  logic              receive_start;
  logic [1:0]        response_type;
  logic              miso;
  logic [RESP_W-1:0] response;
  logic              response_valid;
  logic              timeout;
  logic              receiving;

  modport master (
    output receive_start, response_type, miso,
    input  response, response_valid, timeout, receiving
  );

  modport slave (
    input  receive_start, response_type, miso,
    output response, response_valid, timeout, receiving
  );

endinterface

// File: rtl/sd_response_receiver_prims.sv
// Codebase primitives used by the receiver: a saturating counter with
// clear/parallel load, and a plain enabled D register.
module sync_parallel_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

module register_d #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sd_response_receiver.sv
// SD SPI response receiver: waits for the start bit on MISO, captures R1,
// R1b (with busy wait) or R3/R7 responses, and flags response/busy timeouts.
module sd_response_receiver
  import sd_response_receiver_pkg::*;
#(
  parameter int unsigned NCR_MAX  = NCR_MAX_DEFAULT,
  parameter int unsigned BUSY_MAX = BUSY_MAX_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  sd_response_receiver_if.slave bus
);

  localparam int unsigned        WAIT_W    = wait_cnt_width(NCR_MAX, BUSY_MAX);
  localparam logic [WAIT_W-1:0]  NCR_LIM   = WAIT_W'(NCR_MAX);
  localparam logic [WAIT_W-1:0]  BUSY_LIM  = WAIT_W'(BUSY_MAX);
  localparam logic [BIT_CNT_W-1:0] LAST_R1   = BIT_CNT_W'(LEN_R1 - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_R3R7 = BIT_CNT_W'(LEN_R3R7 - 1);

  rx_state_t            state;
  resp_type_t           type_q;
  logic                 valid_q;
  logic                 timeout_q;
  logic                 receiving_q;

  logic [WAIT_W-1:0]    wait_cnt;
  logic                 wait_clear;
  logic                 wait_en;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 bit_load;
  logic                 bit_en;

  logic [RESP_W-1:0]    shift_q;
  logic [RESP_W-1:0]    shift_d;
  logic [RESP_W-1:0]    shift_next;
  logic                 shift_en;
  logic                 last_bit;

  sync_parallel_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk        (clock),
    .rst        (reset),
    .clear      (wait_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (wait_en),
    .count      (wait_cnt)
  );

  sync_parallel_counter #(.WIDTH(BIT_CNT_W)) u_bit_cnt (
    .clk        (clock),
    .rst        (reset),
    .clear      (1'b0),
    .load       (bit_load),
    .load_value (BIT_CNT_W'(1)),
    .enable     (bit_en),
    .count      (bit_cnt)
  );

  // The shift register doubles as the response holding register: it is
  // cleared on arm, shifts during RECEIVE and is overwritten with the
  // final formatted response (or all-ones on timeout) on completion.
  register_d #(.WIDTH(RESP_W)) u_shift (
    .clk (clock),
    .rst (reset),
    .en  (shift_en),
    .d   (shift_d),
    .q   (shift_q)
  );

  always_comb begin
    shift_next = {shift_q[RESP_W-2:0], bus.miso};
    last_bit   = (bit_cnt == ((type_q == RESP_R3R7) ? LAST_R3R7 : LAST_R1));
    wait_clear = 1'b0;
    wait_en    = 1'b0;
    bit_load   = 1'b0;
    bit_en     = 1'b0;
    shift_en   = 1'b0;
    shift_d    = shift_next;
    case (state)
      S_IDLE: begin
        if (bus.receive_start) begin
          wait_clear = 1'b1;
          shift_en   = 1'b1;
          shift_d    = '0;
        end
      end
      S_WAIT_START: begin
        if (!bus.miso) begin
          shift_en = 1'b1;
          bit_load = 1'b1;
        end else if (wait_cnt == NCR_LIM) begin
          shift_en = 1'b1;
          shift_d  = '1;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_RECEIVE: begin
        shift_en = 1'b1;
        bit_en   = 1'b1;
        if (last_bit && (type_q != RESP_R3R7)) begin
          shift_d = {shift_next[LEN_R1-1:0], 32'h0};
        end
        if (last_bit && (type_q == RESP_R1B)) begin
          wait_clear = 1'b1;
        end
      end
      S_BUSY: begin
        if (!bus.miso && (wait_cnt != BUSY_LIM)) begin
          wait_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      type_q      <= RESP_R1;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      receiving_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.receive_start) begin
            type_q      <= resp_type_t'(bus.response_type);
            receiving_q <= 1'b1;
            state       <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (!bus.miso) begin
            state <= S_RECEIVE;
          end else if (wait_cnt == NCR_LIM) begin
            timeout_q   <= 1'b1;
            receiving_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_RECEIVE: begin
          if (last_bit) begin
            if (type_q == RESP_R1B) begin
              state <= S_BUSY;
            end else begin
              valid_q     <= 1'b1;
              receiving_q <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        S_BUSY: begin
          if (bus.miso) begin
            valid_q     <= 1'b1;
            receiving_q <= 1'b0;
            state       <= S_IDLE;
          end else if (wait_cnt == BUSY_LIM) begin
            timeout_q   <= 1'b1;
            receiving_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.response       = shift_q;
  assign bus.response_valid = valid_q;
  assign bus.timeout        = timeout_q;
  assign bus.receiving      = receiving_q;

endmodule

// File: tb/tb_sd_response_receiver.sv
// Bench for sd_response_receiver: two instances with different busy limits
// share one MISO stream and are checked cycle by cycle against a frame model.
module tb_sd_response_receiver;
  import sd_response_receiver_pkg::*;

  localparam int NCR    = 80;
  localparam int BUSY_A = 48;
  localparam int BUSY_B = 16;
  localparam int SL     = 256;

  logic       clock = 1'b0;
  logic       reset;
  logic       receive_start;
  logic [1:0] response_type;
  logic       miso;

  always #5 clock = ~clock;

  sd_response_receiver_if bus0 ();
  sd_response_receiver_if bus1 ();

  assign bus0.receive_start = receive_start;
  assign bus0.response_type = response_type;
  assign bus0.miso          = miso;
  assign bus1.receive_start = receive_start;
  assign bus1.response_type = response_type;
  assign bus1.miso          = miso;

  sd_response_receiver #(.NCR_MAX(NCR), .BUSY_MAX(BUSY_A)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  sd_response_receiver #(.NCR_MAX(NCR), .BUSY_MAX(BUSY_B)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  logic [39:0] resp_o [2];
  logic        val_o  [2];
  logic        to_o   [2];
  logic        rcv_o  [2];

  assign resp_o[0] = bus0.response;
  assign val_o[0]  = bus0.response_valid;
  assign to_o[0]   = bus0.timeout;
  assign rcv_o[0]  = bus0.receiving;
  assign resp_o[1] = bus1.response;
  assign val_o[1]  = bus1.response_valid;
  assign to_o[1]   = bus1.timeout;
  assign rcv_o[1]  = bus1.receiving;

  bit stream [SL];
  int checks = 0;
  int errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

  // stream[i] is the MISO value sampled on the i-th edge after the arm edge.
  task automatic build(input int idle, input logic [39:0] frame, input int flen, input int busy);
    int k;
    k = 0;
    for (int i = 0; i < SL; i++) stream[i] = 1'($urandom);
    for (int i = 0; i < idle && k < SL; i++) begin stream[k] = 1'b1; k++; end
    for (int i = 0; i < flen && k < SL; i++) begin stream[k] = frame[39-i]; k++; end
    for (int i = 0; i < busy && k < SL; i++) begin stream[k] = 1'b0; k++; end
    if (k < SL) stream[k] = 1'b1;
  endtask

  // kind: 1 = response_valid, 2 = timeout; ev = stream index of the deciding sample.
  function automatic void model(input int busy_max, input logic [1:0] rt,
                                output int kind, output int ev, output logic [39:0] resp);
    int z;
    int len;
    logic [39:0] bits;
    z = -1;
    for (int i = 0; i <= NCR; i++) if (stream[i] == 1'b0) begin z = i; break; end
    if (z < 0) begin
      kind = 2; ev = NCR; resp = '1;
    end else begin
      len  = (rt == 2'd2) ? 40 : 8;
      bits = '0;
      for (int i = 0; i < len; i++) bits = {bits[38:0], stream[z+i]};
      if (rt == 2'd2) begin
        kind = 1; ev = z + 39; resp = bits;
      end else begin
        resp = {bits[7:0], 32'h0};
        if (rt != 2'd1) begin
          kind = 1; ev = z + 7;
        end else begin
          kind = 2; ev = z + 8 + busy_max;
          for (int j = 0; j <= busy_max; j++)
            if (stream[z+8+j]) begin kind = 1; ev = z + 8 + j; break; end
        end
      end
    end
  endfunction

  task automatic run_frame(input string name, input logic [1:0] rt, input bit glitch);
    int kind [2];
    int ev   [2];
    logic [39:0] er [2];
    int last;
    int gat;
    logic ev_v, ev_t, ev_r;
    model(BUSY_A, rt, kind[0], ev[0], er[0]);
    model(BUSY_B, rt, kind[1], ev[1], er[1]);
    last = (ev[0] > ev[1]) ? ev[0] : ev[1];
    gat  = glitch ? (((ev[0] < ev[1]) ? ev[0] : ev[1]) / 2) : -1;
    @(negedge clock);
    receive_start = 1'b1;
    response_type = rt;
    miso          = 1'b1;
    @(posedge clock);
    @(negedge clock);
    receive_start = 1'b0;
    response_type = 2'($urandom);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rcv_o[d] !== 1'b1 || val_o[d] !== 1'b0 || to_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s_arm dut%0d rcv/val/to got %b%b%b exp 100", name, d, rcv_o[d], val_o[d], to_o[d]);
      end
    end
    for (int i = 0; i <= last + 1; i++) begin
      miso          = stream[i];
      receive_start = (i == gat);
      if (i == gat) response_type = 2'($urandom);
      @(posedge clock);
      @(negedge clock);
      receive_start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        ev_v = (i == ev[d]) && (kind[d] == 1);
        ev_t = (i == ev[d]) && (kind[d] == 2);
        ev_r = (i < ev[d]);
        checks++;
        if (val_o[d] !== ev_v) begin
          errors++;
          $display("FAIL %s_valid dut%0d cyc %0d got %b exp %b", name, d, i, val_o[d], ev_v);
        end
        checks++;
        if (to_o[d] !== ev_t) begin
          errors++;
          $display("FAIL %s_timeout dut%0d cyc %0d got %b exp %b", name, d, i, to_o[d], ev_t);
        end
        checks++;
        if (rcv_o[d] !== ev_r) begin
          errors++;
          $display("FAIL %s_receiving dut%0d cyc %0d got %b exp %b", name, d, i, rcv_o[d], ev_r);
        end
        if (i == ev[d] || i == ev[d] + 1) begin
          checks++;
          if (resp_o[d] !== er[d]) begin
            errors++;
            $display("FAIL %s_response dut%0d cyc %0d got %h exp %h", name, d, i, resp_o[d], er[d]);
          end
        end
      end
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (resp_o[d] !== 40'h0 || val_o[d] !== 1'b0 || to_o[d] !== 1'b0 || rcv_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d resp %h val %b to %b rcv %b exp all zero",
                 name, d, resp_o[d], val_o[d], to_o[d], rcv_o[d]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    check_zero("reset_held");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset_released");
  endtask

  task automatic test_r1();
    build(3, {8'h01, 32'h0}, 8, 0);
    run_frame("r1", 2'd0, 1'b0);
  endtask

  task automatic test_r7();
    build(5, 40'h01_0000_01AA, 40, 0);
    run_frame("r7", 2'd2, 1'b1);
  endtask

  task automatic test_r1b();
    build(2, {8'h00, 32'h0}, 8, 20);
    run_frame("r1b", 2'd1, 1'b0);
  endtask

  task automatic test_no_response();
    build(NCR + 1, '1, 0, 0);
    run_frame("no_resp", 2'd0, 1'b0);
  endtask

  task automatic test_busy_timeout();
    build(2, {8'h05, 32'h0}, 8, 200);
    run_frame("busy_to", 2'd1, 1'b0);
  endtask

  task automatic test_boundaries();
    build(NCR, {8'h01, 32'h0}, 8, 0);
    run_frame("ncr_edge_ok", 2'd0, 1'b0);
    build(NCR + 1, {8'h01, 32'h0}, 8, 0);
    run_frame("ncr_edge_to", 2'd0, 1'b0);
    build(1, {8'h07, 32'h0}, 8, BUSY_B);
    run_frame("busy_edge_ok", 2'd1, 1'b0);
    build(1, {8'h07, 32'h0}, 8, BUSY_B + 1);
    run_frame("busy_edge_to", 2'd1, 1'b0);
    build(4, {8'h11, 32'h0}, 8, 0);
    run_frame("type3", 2'd3, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    build(2, 40'h01_DEAD_BEEF, 40, 0);
    @(negedge clock);
    receive_start = 1'b1;
    response_type = 2'd2;
    @(posedge clock);
    @(negedge clock);
    receive_start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      miso          = stream[i];
      receive_start = (i == 10);
      response_type = 2'd0;
      @(posedge clock);
      @(negedge clock);
      receive_start = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rcv_o[d] !== 1'b1) begin
        errors++;
        $display("FAIL mid_receiving dut%0d got %b exp 1", d, rcv_o[d]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clock);
    @(negedge clock);
    check_zero("reset_hold");
    reset = 1'b0;
    build(1, {8'h2C, 32'h0}, 8, 0);
    run_frame("after_reset", 2'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  rt;
    logic [39:0] f;
    int idle;
    int busy;
    int sel;
    for (int n = 0; n < 40; n++) begin
      rt     = 2'($urandom_range(0, 3));
      f      = {8'($urandom), 32'($urandom)};
      f[39]  = 1'b0;
      idle   = ($urandom_range(0, 7) == 0) ? $urandom_range(NCR - 1, NCR + 1) : $urandom_range(0, 10);
      sel    = $urandom_range(0, 3);
      busy   = (sel == 0) ? $urandom_range(BUSY_B - 1, BUSY_B + 2) :
               (sel == 1) ? $urandom_range(BUSY_A - 1, BUSY_A + 1) : $urandom_range(0, 12);
      build(idle, f, (rt == 2'd2) ? 40 : 8, busy);
      run_frame("random", rt, 1'($urandom));
    end
  endtask

  initial begin
    reset         = 1'b1;
    receive_start = 1'b0;
    response_type = 2'd0;
    miso          = 1'b1;
    test_reset();
    test_r1();
    test_r7();
    test_r1b();
    test_no_response();
    test_busy_timeout();
    test_boundaries();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
